// File: rtl/serial_adder_n.sv
// Multi-cycle adder/subtractor that processes CHUNK bits per clock, least
// significant chunk first. It produces the carry/borrow and signed overflow.
module serial_adder_n #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             start_in,
  input  logic             sub_in,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             c_in,
  output logic             busy_out,
  output logic             done_out,
  output logic [WIDTH-1:0] sum_out,
  output logic             carry_out,
  output logic             overflow_out
);

  localparam int N  = WIDTH / CHUNK;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic             sub_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] acc;

  logic [CHUNK-1:0] ca;
  logic [CHUNK-1:0] cb;
  logic [CHUNK-1:0] cs;
  logic             c_hi;
  logic             c_msb_in;
  logic             last;
  logic [WIDTH-1:0] acc_next;

  // Subtraction runs as a + ~b + ~borrow_in, so b is inverted chunk by chunk.
  always_comb begin
    ca           = a_r[cnt*CHUNK +: CHUNK];
    cb           = sub_r ? ~b_r[cnt*CHUNK +: CHUNK] : b_r[cnt*CHUNK +: CHUNK];
    {c_hi, cs}   = {1'b0, ca} + {1'b0, cb} + {{CHUNK{1'b0}}, carry};
    c_msb_in     = ca[CHUNK-1] ^ cb[CHUNK-1] ^ cs[CHUNK-1];
    last         = (cnt == CW'(N - 1));
    acc_next     = acc;
    acc_next[cnt*CHUNK +: CHUNK] = cs;
  end

  always_comb begin
    busy_out = (state == RUN);
    done_out = (state == DONE);
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state        <= IDLE;
      cnt          <= '0;
      carry        <= 1'b0;
      sub_r        <= 1'b0;
      a_r          <= '0;
      b_r          <= '0;
      acc          <= '0;
      sum_out      <= '0;
      carry_out    <= 1'b0;
      overflow_out <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start_in) begin
            a_r   <= a_in;
            b_r   <= b_in;
            sub_r <= sub_in;
            carry <= sub_in ? ~c_in : c_in;
            cnt   <= '0;
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          acc   <= acc_next;
          carry <= c_hi;
          if (last) begin
            cnt          <= '0;
            state        <= DONE;
            sum_out      <= acc_next;
            carry_out    <= c_hi ^ sub_r;
            overflow_out <= c_hi ^ c_msb_in;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder_n.sv
// Scoreboard bench for serial_adder_n. It drives two builds: CHUNK=4 (index 0)
// and CHUNK=16 (index 1), each with its own stimulus and expected-result queue.
module tb_serial_adder_n;

  typedef struct {
    logic [15:0] sum;
    logic        c;
    logic        v;
    int unsigned cyc;
  } exp_t;

  logic        clk;
  logic        rst   [2];
  logic        start [2];
  logic        sub   [2];
  logic [15:0] a     [2];
  logic [15:0] b     [2];
  logic        cin   [2];
  logic        busy  [2];
  logic        done  [2];
  logic [15:0] sum   [2];
  logic        cout  [2];
  logic        ovf   [2];

  exp_t        q0[$];
  exp_t        q1[$];
  int unsigned cyc;
  int unsigned checks;
  int unsigned errors;

  serial_adder_n #(.WIDTH(16), .CHUNK(4)) u_dut4 (
    .clk_in(clk), .rst_in(rst[0]), .start_in(start[0]), .sub_in(sub[0]),
    .a_in(a[0]), .b_in(b[0]), .c_in(cin[0]), .busy_out(busy[0]),
    .done_out(done[0]), .sum_out(sum[0]), .carry_out(cout[0]),
    .overflow_out(ovf[0])
  );

  serial_adder_n #(.WIDTH(16), .CHUNK(16)) u_dut16 (
    .clk_in(clk), .rst_in(rst[1]), .start_in(start[1]), .sub_in(sub[1]),
    .a_in(a[1]), .b_in(b[1]), .c_in(cin[1]), .busy_out(busy[1]),
    .done_out(done[1]), .sum_out(sum[1]), .carry_out(cout[1]),
    .overflow_out(ovf[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int unsigned n_of(input int unsigned s);
    return (s == 0) ? 4 : 1;
  endfunction

  task automatic push_exp(input int unsigned s, input logic [15:0] es,
                          input logic ec, input logic ev, input int unsigned dcyc);
    exp_t e;
    e.sum = es; e.c = ec; e.v = ev; e.cyc = dcyc;
    if (s == 0) q0.push_back(e); else q1.push_back(e);
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic issue(input int unsigned s, input logic [15:0] av, input logic [15:0] bv,
                       input logic c, input logic sb, input logic [15:0] es,
                       input logic ec, input logic ev, input bit push, input bit hold);
    a[s] = av; b[s] = bv; cin[s] = c; sub[s] = sb; start[s] = 1'b1;
    if (push) push_exp(s, es, ec, ev, cyc + 1 + n_of(s));
    @(posedge clk);
    @(negedge clk);
    if (!hold) start[s] = 1'b0;
  endtask

  task automatic wait_done(input int unsigned s, output int unsigned busy_cnt);
    bit seen;
    busy_cnt = 0;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done[s]) begin
        seen = 1'b1;
        break;
      end
      if (busy[s]) busy_cnt++;
      @(negedge clk);
    end
    chk("done_timeout", {31'b0, seen}, 32'd1);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst[0] && done[0]) begin
      if (q0.size() == 0) begin
        chk("unexpected_done4", 32'd1, 32'd0);
      end else begin
        e = q0.pop_front();
        chk("sum4", {16'b0, sum[0]}, {16'b0, e.sum});
        chk("carry4", {31'b0, cout[0]}, {31'b0, e.c});
        chk("ovf4", {31'b0, ovf[0]}, {31'b0, e.v});
        chk("latency4", cyc, e.cyc);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst[1] && done[1]) begin
      if (q1.size() == 0) begin
        chk("unexpected_done16", 32'd1, 32'd0);
      end else begin
        e = q1.pop_front();
        chk("sum16", {16'b0, sum[1]}, {16'b0, e.sum});
        chk("carry16", {31'b0, cout[1]}, {31'b0, e.c});
        chk("ovf16", {31'b0, ovf[1]}, {31'b0, e.v});
        chk("latency16", cyc, e.cyc);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int unsigned bc;
    checks = 0;
    errors = 0;
    for (int s = 0; s < 2; s++) begin
      rst[s] = 1'b1; start[s] = 1'b0; sub[s] = 1'b0;
      a[s] = '0; b[s] = '0; cin[s] = 1'b0;
    end
    repeat (3) @(negedge clk);
    for (int unsigned s = 0; s < 2; s++) begin
      chk("rst_busy", {31'b0, busy[s]}, 32'd0);
      chk("rst_done", {31'b0, done[s]}, 32'd0);
      chk("rst_sum", {16'b0, sum[s]}, 32'd0);
      chk("rst_flags", {30'b0, cout[s], ovf[s]}, 32'd0);
    end
    rst[0] = 1'b0; rst[1] = 1'b0;
    @(negedge clk);

    // Corner vectors on both builds
    for (int unsigned s = 0; s < 2; s++) begin
      issue(s, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1, 0);
      wait_done(s, bc); chk("busy_len", bc, n_of(s));
      issue(s, 16'h7FFF, 16'h0001, 1'b1, 1'b0, 16'h8001, 1'b0, 1'b1, 1, 0);
      wait_done(s, bc); chk("busy_len", bc, n_of(s));
      issue(s, 16'h0003, 16'h0005, 1'b0, 1'b1, 16'hFFFE, 1'b1, 1'b0, 1, 0);
      wait_done(s, bc); chk("busy_len", bc, n_of(s));
      issue(s, 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b0, 1'b1, 1, 0);
      wait_done(s, bc); chk("busy_len", bc, n_of(s));
      @(negedge clk);
      chk("hold_sum", {16'b0, sum[s]}, 32'h7FFF);
    end

    // Start during RUN must be ignored
    issue(0, 16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345, 1'b0, 1'b0, 1, 0);
    chk("busy_first", {31'b0, busy[0]}, 32'd1);
    a[0] = 16'hFFFF; b[0] = 16'hFFFF; start[0] = 1'b1;
    @(negedge clk);
    chk("sum_hold_run", {16'b0, sum[0]}, 32'h7FFF);
    start[0] = 1'b0;
    wait_done(0, bc); chk("busy_len_ignore", bc + 1, 32'd4);
    repeat (3) @(negedge clk);

    // Reset in the 2nd RUN cycle aborts silently
    issue(0, 16'h0005, 16'h0003, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 0, 0);
    @(negedge clk);
    rst[0] = 1'b1;
    #1;
    chk("abort_busy", {31'b0, busy[0]}, 32'd0);
    chk("abort_done", {31'b0, done[0]}, 32'd0);
    chk("abort_sum", {16'b0, sum[0]}, 32'd0);
    chk("abort_flags", {30'b0, cout[0], ovf[0]}, 32'd0);
    @(negedge clk);
    rst[0] = 1'b0;
    repeat (6) @(negedge clk);
    chk("abort_no_done", {31'b0, done[0]}, 32'd0);
    issue(0, 16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0, 1, 0);
    wait_done(0, bc); chk("busy_len_post_rst", bc, 32'd4);

    // Back-to-back: start held through DONE
    @(negedge clk);
    issue(0, 16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0, 1, 1);
    a[0] = 16'h1000; b[0] = 16'h0001; sub[0] = 1'b1; cin[0] = 1'b0;
    wait_done(0, bc); chk("busy_len_b2b1", bc, 32'd4);
    push_exp(0, 16'h0FFF, 1'b0, 1'b0, cyc + 1 + 4);
    @(posedge clk);
    @(negedge clk);
    start[0] = 1'b0;
    chk("b2b_no_idle", {31'b0, busy[0]}, 32'd1);
    wait_done(0, bc); chk("busy_len_b2b2", bc, 32'd4);

    repeat (4) @(negedge clk);
    chk("queue_empty", q0.size() + q1.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
